mem_stage_lsu: RTL and testbench

- MEM-stage load/store unit for the RV32I 5-stage pipeline.
- Consumes the EX/MEM pipeline register outputs: memory_read/write, funct3, alu_result as address, read_data2 as store data.
- Drives a valid/ready data-memory port, generates byte strobes and lane-replicated store data, and sign/zero-extends load data for MEM/WB.
- Holds the pipeline with `stall` while an access is outstanding; flags misaligned or illegal accesses instead of issuing them.

---
 rtl/rv32_mem_pkg.sv | 31 +++
 rtl/mem_stage_lsu_if.sv | 26 ++
 rtl/lsu_align.sv | 55 +++++
 rtl/mem_stage_lsu.sv | 124 ++++++++++++
 tb/tb_mem_stage_lsu.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//   - funct3 access-size encodings (RV32I loads/stores)
//   - lsu_state_t: LSU sequencing states
//   - is_aligned(): natural-alignment check for an access size
package rv32_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } lsu_state_t;

  // funct3[1:0] encodes the size for both signed and unsigned forms. The reserved
  // size 2'b11 reports aligned so that it is flagged only as illegal.
  function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b00:   return 1'b1;
      2'b01:   return ~addr_lo[0];
      2'b10:   return addr_lo == 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory port between the LSU (master) and the memory (slave).
//   req_valid/req_ready : request handshake
//   addr, we, wstrb, wdata : request payload, stable while req_valid is high
//   rsp_valid, rsp_rdata   : read response (reads only)
interface mem_stage_lsu_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] addr;
  logic            we;
  logic [3:0]      wstrb;
  logic [XLEN-1:0] wdata;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;

  modport master (
    output req_valid, addr, we, wstrb, wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, addr, we, wstrb, wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU, purely combinational.
//   Store path: st_funct3, st_addr_lo, st_data -> wstrb, wdata (lane-replicated)
//   Load path : ld_funct3, ld_addr_lo, rdata   -> ld_data (extracted and extended)
module lsu_align
  import rv32_mem_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    wstrb = 4'b0000;
    wdata = '0;
    case (st_funct3)
      F3_B: begin
        wstrb = 4'b0001 << st_addr_lo;
        wdata = {4{st_data[7:0]}};
      end
      F3_H: begin
        wstrb = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{st_data[15:0]}};
      end
      F3_W: begin
        wstrb = 4'b1111;
        wdata = st_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = rdata[{ld_addr_lo, 3'b000} +: 8];
    ld_half = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
    ld_data = '0;
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'b0, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'b0, ld_half};
      F3_W:    ld_data = rdata;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit for the RV32I pipeline.
//   clk, reset (async, active-high), flush : control
//   MEM_* : EX/MEM register outputs (read/write, funct3, address, store data)
//   dmem  : valid/ready data-memory port (master side)
//   load_data, load_data_valid : extended load result for MEM/WB (1-cycle pulse)
//   stall : holds IF..MEM while an access is in flight
//   load_misaligned, store_misaligned, illegal_access : fault flags, raised in IDLE
module mem_stage_lsu
  import rv32_mem_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 MEM_memory_read,
  input  logic                 MEM_memory_write,
  input  logic [2:0]           MEM_funct3,
  input  logic [XLEN-1:0]      MEM_alu_result,
  input  logic [XLEN-1:0]      MEM_read_data2,
  mem_stage_lsu_if.master      dmem,
  output logic [XLEN-1:0]      load_data,
  output logic                 load_data_valid,
  output logic                 stall,
  output logic                 load_misaligned,
  output logic                 store_misaligned,
  output logic                 illegal_access
);

  lsu_state_t      state_q, state_d;
  logic [XLEN-1:0] addr_q, wdata_q, load_data_q;
  logic [3:0]      wstrb_q;
  logic [2:0]      funct3_q;
  logic            we_q, flushed_q;

  logic            access, legal, aligned, consider, issue;
  logic [3:0]      st_wstrb;
  logic [XLEN-1:0] st_wdata, ld_ext;

  // Read and write together is treated as a store.
  assign access   = MEM_memory_read | MEM_memory_write;
  assign aligned  = is_aligned(MEM_funct3, MEM_alu_result[1:0]);
  assign consider = (state_q == IDLE) & access & ~flush;
  assign issue    = consider & legal & aligned;

  always_comb begin
    legal = 1'b0;
    case (MEM_funct3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = ~MEM_memory_write;
      default:          legal = 1'b0;
    endcase
  end

  assign illegal_access   = consider & ~legal;
  assign load_misaligned  = consider & legal & ~aligned & ~MEM_memory_write;
  assign store_misaligned = consider & legal & ~aligned & MEM_memory_write;

  lsu_align u_align (
    .st_funct3  (MEM_funct3),
    .st_addr_lo (MEM_alu_result[1:0]),
    .st_data    (MEM_read_data2),
    .wstrb      (st_wstrb),
    .wdata      (st_wdata),
    .ld_funct3  (funct3_q),
    .ld_addr_lo (addr_q[1:0]),
    .rdata      (dmem.rsp_rdata),
    .ld_data    (ld_ext)
  );

  // A flush coinciding with the handshake cannot recall the request: the memory
  // already owns it, so the access completes and only the load result is dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (issue) state_d = REQ;
      REQ: begin
        if (dmem.req_ready)  state_d = we_q ? DONE : WAIT;
        else if (flush)      state_d = IDLE;
      end
      WAIT: if (dmem.rsp_valid) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wstrb_q     <= 4'b0000;
      wdata_q     <= '0;
      funct3_q    <= F3_B;
      flushed_q   <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        addr_q    <= MEM_alu_result;
        we_q      <= MEM_memory_write;
        wstrb_q   <= MEM_memory_write ? st_wstrb : 4'b0000;
        wdata_q   <= MEM_memory_write ? st_wdata : '0;
        funct3_q  <= MEM_funct3;
        flushed_q <= 1'b0;
      end else if (flush && (state_q == REQ || state_q == WAIT)) begin
        flushed_q <= 1'b1;
      end
      // Response is consumed even when flushed; only the valid pulse is suppressed.
      if (state_q == WAIT && dmem.rsp_valid) load_data_q <= ld_ext;
    end
  end

  assign dmem.req_valid  = (state_q == REQ);
  assign dmem.addr       = addr_q;
  assign dmem.we         = we_q;
  assign dmem.wstrb      = wstrb_q;
  assign dmem.wdata      = wdata_q;

  assign stall           = issue | (state_q == REQ) | (state_q == WAIT);
  assign load_data       = load_data_q;
  assign load_data_valid = (state_q == DONE) & ~we_q & ~flushed_q & ~flush;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu.
module tb_mem_stage_lsu;
  import rv32_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, mem_rd, mem_wr;
  logic [2:0]  f3;
  logic [31:0] alu, rs2;
  logic [31:0] load_data;
  logic        ldv, stall, lmis, smis, ill;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage_lsu_if #(.XLEN(32)) dmem ();

  mem_stage_lsu #(.XLEN(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .MEM_memory_read  (mem_rd),
    .MEM_memory_write (mem_wr),
    .MEM_funct3       (f3),
    .MEM_alu_result   (alu),
    .MEM_read_data2   (rs2),
    .dmem             (dmem),
    .load_data        (load_data),
    .load_data_valid  (ldv),
    .stall            (stall),
    .load_misaligned  (lmis),
    .store_misaligned (smis),
    .illegal_access   (ill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    mem_rd = 1'b0; mem_wr = 1'b0; f3 = 3'b000; alu = '0; rs2 = '0; flush = 1'b0;
    dmem.req_ready = 1'b0; dmem.rsp_valid = 1'b0; dmem.rsp_rdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one access from IDLE to DONE. Cycle 0 is the IDLE cycle; ready rises at
  // cycle 1+rdy_lat (or is high throughout when rdy_lat is 0); for loads the
  // response arrives at cycle 2+rdy_lat+rsp_lat.
  task automatic do_access(input string tag, input logic wr, input logic [2:0] fn,
                           input logic [31:0] a, input logic [31:0] d,
                           input int rdy_lat, input int rsp_lat, input logic [31:0] rdata,
                           input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
                           input logic [31:0] exp_ld, input int exp_stalls);
    int cyc = 0, stalls = 0, reqs = 0, unstable = 0, pulses = 0;
    bit done = 1'b0, seen_req = 1'b0;
    logic [3:0] got_wstrb = '0;
    logic [31:0] got_wdata = '0, got_ld = '0;
    logic got_we = 1'b0;
    mem_rd = ~wr; mem_wr = wr; f3 = fn; alu = a; rs2 = d;
    while (!done && cyc < 40) begin
      dmem.req_ready = (rdy_lat == 0) || (cyc >= 1 + rdy_lat);
      dmem.rsp_valid = !wr && (cyc == 2 + rdy_lat + rsp_lat);
      dmem.rsp_rdata = dmem.rsp_valid ? rdata : 32'hCAFE_F00D;
      @(negedge clk);
      if (stall) stalls++;
      if (dmem.req_valid) begin
        if (!seen_req) begin
          seen_req = 1'b1; got_wstrb = dmem.wstrb; got_wdata = dmem.wdata; got_we = dmem.we;
        end
        reqs++;
        if (dmem.addr !== a || dmem.wstrb !== got_wstrb || dmem.wdata !== got_wdata ||
            dmem.we !== got_we) unstable++;
      end
      if (ldv) begin
        pulses++;
        got_ld = load_data;
      end
      if (cyc > 0 && !stall) done = 1'b1;
      next_cycle();
      cyc++;
    end
    clear_inputs();
    chk({tag, " completed"}, 32'(done), 32'd1);
    chk({tag, " stall cycles"}, 32'(stalls), 32'(exp_stalls));
    chk({tag, " req cycles"}, 32'(reqs), 32'(1 + rdy_lat));
    chk({tag, " payload unstable"}, 32'(unstable), 32'd0);
    chk({tag, " we"}, 32'(got_we), 32'(wr));
    chk({tag, " wstrb"}, 32'(got_wstrb), 32'(exp_wstrb));
    if (wr) chk({tag, " wdata"}, got_wdata, exp_wdata);
    chk({tag, " ldv pulses"}, 32'(pulses), wr ? 32'd0 : 32'd1);
    if (!wr) chk({tag, " load_data"}, got_ld, exp_ld);
    @(negedge clk);
    chk({tag, " after ldv/stall/req"}, {29'b0, ldv, stall, dmem.req_valid}, 32'd0);
    next_cycle();
  endtask

  task automatic do_fault(input string tag, input logic wr, input logic [2:0] fn,
                          input logic [31:0] a, input logic [2:0] exp_flags);
    mem_rd = ~wr; mem_wr = wr; f3 = fn; alu = a; rs2 = 32'h1111_2222;
    dmem.req_ready = 1'b1;
    @(negedge clk);
    chk({tag, " flags"}, {29'b0, lmis, smis, ill}, {29'b0, exp_flags});
    chk({tag, " stall"}, 32'(stall), 32'd0);
    chk({tag, " req_valid"}, 32'(dmem.req_valid), 32'd0);
    next_cycle();
    clear_inputs();
    dmem.req_ready = 1'b1;
    @(negedge clk);
    chk({tag, " next flags/req/stall"}, {27'b0, lmis, smis, ill, dmem.req_valid, stall}, 32'd0);
    next_cycle();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset ctrl", {27'b0, dmem.req_valid, dmem.we, ldv, stall, lmis | smis | ill}, 32'd0);
    chk("reset wstrb", 32'(dmem.wstrb), 32'd0);
    chk("reset addr", dmem.addr, 32'd0);
    chk("reset wdata", dmem.wdata, 32'd0);
    chk("reset load_data", load_data, 32'd0);
    next_cycle();
    reset = 1'b0;
    next_cycle();

    // Stores
    do_access("sw", 1'b1, F3_W, 32'h100, 32'hDEAD_BEEF, 0, 0, 32'h0,
              4'b1111, 32'hDEAD_BEEF, 32'h0, 2);
    do_access("sb", 1'b1, F3_B, 32'h103, 32'h0000_00A5, 0, 0, 32'h0,
              4'b1000, 32'hA5A5_A5A5, 32'h0, 2);
    do_access("sh hi", 1'b1, F3_H, 32'h102, 32'h0000_1234, 0, 0, 32'h0,
              4'b1100, 32'h1234_1234, 32'h0, 2);
    do_access("sh lo", 1'b1, F3_H, 32'h100, 32'hFFFF_5678, 0, 0, 32'h0,
              4'b0011, 32'h5678_5678, 32'h0, 2);
    do_access("sw slow", 1'b1, F3_W, 32'h104, 32'h0BAD_F00D, 2, 0, 32'h0,
              4'b1111, 32'h0BAD_F00D, 32'h0, 4);

    // Loads
    do_access("lb", 1'b0, F3_B, 32'h201, 32'h0, 0, 0, 32'h0000_8000,
              4'b0000, 32'h0, 32'hFFFF_FF80, 3);
    do_access("lbu", 1'b0, F3_BU, 32'h201, 32'h0, 0, 0, 32'h0000_8000,
              4'b0000, 32'h0, 32'h0000_0080, 3);
    do_access("lhu", 1'b0, F3_HU, 32'h202, 32'h0, 0, 0, 32'hBEEF_0000,
              4'b0000, 32'h0, 32'h0000_BEEF, 3);
    do_access("lh", 1'b0, F3_H, 32'h202, 32'h0, 0, 0, 32'hBEEF_0000,
              4'b0000, 32'h0, 32'hFFFF_BEEF, 3);
    do_access("lw slow", 1'b0, F3_W, 32'h300, 32'h0, 3, 1, 32'h89AB_CDEF,
              4'b0000, 32'h0, 32'h89AB_CDEF, 7);

    // Faults: flags are {load_misaligned, store_misaligned, illegal_access}
    do_fault("lw misaligned", 1'b0, F3_W, 32'h302, 3'b100);
    do_fault("lh misaligned", 1'b0, F3_H, 32'h203, 3'b100);
    do_fault("sw misaligned", 1'b1, F3_W, 32'h101, 3'b010);
    do_fault("sh misaligned", 1'b1, F3_H, 32'h103, 3'b010);
    do_fault("load f3 011", 1'b0, 3'b011, 32'h100, 3'b001);
    do_fault("store f3 100", 1'b1, F3_BU, 32'h100, 3'b001);

    // Reset while waiting for a load response; a late response must be ignored.
    mem_rd = 1'b1; f3 = F3_W; alu = 32'h400; dmem.req_ready = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst-in-wait stall before", 32'(stall), 32'd1);
    #1;
    reset = 1'b1;
    clear_inputs();
    #1;
    chk("rst-in-wait ctrl", {27'b0, dmem.req_valid, dmem.we, ldv, stall, lmis | smis | ill}, 32'd0);
    chk("rst-in-wait addr", dmem.addr, 32'd0);
    next_cycle();
    reset = 1'b0;
    dmem.rsp_valid = 1'b1;
    dmem.rsp_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("late rsp ldv/stall/req", {29'b0, ldv, stall, dmem.req_valid}, 32'd0);
      chk("late rsp load_data", load_data, 32'd0);
      next_cycle();
    end
    clear_inputs();

    // Flush in REQ before ready: request withdrawn, nothing issued afterwards.
    mem_rd = 1'b1; f3 = F3_W; alu = 32'h500;
    next_cycle();
    flush = 1'b1;
    @(negedge clk);
    chk("flush-req req_valid", 32'(dmem.req_valid), 32'd1);
    next_cycle();
    clear_inputs();
    dmem.req_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("flush-req after req/stall", {30'b0, dmem.req_valid, stall}, 32'd0);
      next_cycle();
    end
    clear_inputs();

    // Flush in WAIT: the response is consumed but no load_data_valid pulse.
    mem_rd = 1'b1; f3 = F3_W; alu = 32'h600; dmem.req_ready = 1'b1;
    next_cycle();
    next_cycle();
    flush = 1'b1;
    dmem.rsp_valid = 1'b1;
    dmem.rsp_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("flush-wait stall", 32'(stall), 32'd1);
    next_cycle();
    flush = 1'b0;
    dmem.rsp_valid = 1'b0;
    @(negedge clk);
    chk("flush-wait done ldv/stall", {30'b0, ldv, stall}, 32'd0);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    chk("flush-wait idle ldv/req", {30'b0, ldv, dmem.req_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
